// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash responder.
package spi_flash_pkg;

  localparam int unsigned ADDR_BITS_SPI = 24;
  localparam int unsigned BIT_CNT_W     = 5;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes the asynchronous SPI pins into clk and flags SCK/CS edges.
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   sck, cs, mosi  raw SPI pins
//   cs_s, mosi_s   synchronized CS level and MOSI
//   sck_rise_c     synchronized SCK rose this clk
//   sck_fall_c     synchronized SCK fell this clk
//   cs_fall_c      synchronized CS fell this clk
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sck_rise_c,
  output logic sck_fall_c,
  output logic cs_fall_c
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_prev;
  logic                   cs_prev;

  // Synchronizer chains; CS resets to its idle (deselected) level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_q    <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q     <= {cs_q[SYNC_STAGES-2:0], cs};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_prev <= sck_q[SYNC_STAGES-1];
      cs_prev  <= cs_q[SYNC_STAGES-1];
    end
  end

  assign cs_s       = cs_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_q[SYNC_STAGES-1];
  assign sck_rise_c = sck_q[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall_c = ~sck_q[SYNC_STAGES-1] & sck_prev;
  assign cs_fall_c  = ~cs_q[SYNC_STAGES-1] & cs_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash emulator: decodes READ/RDID/RDSR and streams bytes
// from an external byte-wide read port.
// Ports:
//   clk, reset_n                  system clock, synchronous active-low reset
//   i_SPI_CLK/i_SPI_CS/i_SPI_MOSI SPI pins from the initiator (async)
//   o_SPI_MISO, o_SPI_MISO_OE     serial response and its pad enable
//   o_MEM_ADDR, o_MEM_RD          backing memory address and 1-clk read strobe
//   i_MEM_DATA                    read data, valid the clk after o_MEM_RD
//   o_BUSY                        synchronized CS is low
//   o_CMD                         last complete opcode
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_SPI_CLK,
  input  logic              i_SPI_CS,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO,
  output logic              o_SPI_MISO_OE,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic              o_MEM_RD,
  input  logic [7:0]        i_MEM_DATA,
  output logic              o_BUSY,
  output logic [7:0]        o_CMD
);

  localparam logic [BIT_CNT_W-1:0] LAST_BYTE_BIT = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] LAST_ADDR_BIT = BIT_CNT_W'(ADDR_BITS_SPI - 1);

  logic cs_s, mosi_s, sck_rise, sck_fall, cs_fall;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sck        (i_SPI_CLK),
    .cs         (i_SPI_CS),
    .mosi       (i_SPI_MOSI),
    .cs_s       (cs_s),
    .mosi_s     (mosi_s),
    .sck_rise_c (sck_rise),
    .sck_fall_c (sck_fall),
    .cs_fall_c  (cs_fall)
  );

  state_t                state, state_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [6:0]            rx_sr, rx_nxt;
  logic [ADDR_W-2:0]     addr_sr, addr_nxt;
  logic [7:0]            tx_sr, tx_nxt;
  logic                  miso, miso_nxt;
  logic                  miso_oe, oe_nxt;
  logic [ADDR_W-1:0]     mem_addr, mem_addr_nxt;
  logic                  mem_rd, mem_rd_nxt;
  logic                  load_pend, load_nxt;
  logic                  busy, busy_nxt;
  logic [7:0]            cmd, cmd_nxt;
  logic [1:0]            id_idx, id_idx_nxt;
  logic [7:0]            rx_byte;
  logic [ADDR_W-1:0]     addr_word;
  logic [7:0]            tx_cur;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      default: return JEDEC_ID[7:0];
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      addr_sr   <= '0;
      tx_sr     <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      load_pend <= 1'b0;
      busy      <= 1'b0;
      cmd       <= '0;
      id_idx    <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sr     <= rx_nxt;
      addr_sr   <= addr_nxt;
      tx_sr     <= tx_nxt;
      miso      <= miso_nxt;
      miso_oe   <= oe_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_rd    <= mem_rd_nxt;
      load_pend <= load_nxt;
      busy      <= busy_nxt;
      cmd       <= cmd_nxt;
      id_idx    <= id_idx_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    rx_nxt       = rx_sr;
    addr_nxt     = addr_sr;
    tx_nxt       = tx_sr;
    miso_nxt     = miso;
    oe_nxt       = miso_oe;
    mem_addr_nxt = mem_addr;
    mem_rd_nxt   = 1'b0;
    load_nxt     = mem_rd;   // memory data arrives the clk after the strobe
    busy_nxt     = ~cs_s;
    cmd_nxt      = cmd;
    id_idx_nxt   = id_idx;
    rx_byte      = {rx_sr, mosi_s};
    addr_word    = {addr_sr, mosi_s};
    tx_cur       = load_pend ? i_MEM_DATA : tx_sr;

    if (cs_s) begin
      // Deselect beats any SCK edge seen in the same clk.
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
      miso_nxt    = 1'b0;
      load_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state_nxt   = ST_CMD;
            bit_cnt_nxt = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_nxt      = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BYTE_BIT) begin
              bit_cnt_nxt = '0;
              cmd_nxt     = rx_byte;
              case (rx_byte)
                CMD_READ: state_nxt = ST_ADDR;
                CMD_RDID: begin
                  state_nxt  = ST_ID;
                  tx_nxt     = id_byte(2'd0);
                  id_idx_nxt = 2'd1;
                  oe_nxt     = 1'b1;
                end
                CMD_RDSR: begin
                  state_nxt = ST_STAT;
                  tx_nxt    = 8'h00;
                  oe_nxt    = 1'b1;
                end
                default: state_nxt = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            addr_nxt    = addr_word[ADDR_W-2:0];
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_ADDR_BIT) begin
              bit_cnt_nxt  = '0;
              mem_addr_nxt = addr_word;
              mem_rd_nxt   = 1'b1;
              oe_nxt       = 1'b1;
              state_nxt    = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          tx_nxt = tx_cur;
          if (sck_fall) begin
            miso_nxt = tx_cur[7];
            tx_nxt   = {tx_cur[6:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BYTE_BIT) begin
              // Prefetch the next byte; the address wraps at 2^ADDR_W.
              bit_cnt_nxt  = '0;
              mem_addr_nxt = mem_addr + ADDR_W'(1);
              mem_rd_nxt   = 1'b1;
            end
          end
        end
        ST_ID, ST_STAT: begin
          if (sck_fall) begin
            miso_nxt = tx_sr[7];
            tx_nxt   = {tx_sr[6:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BYTE_BIT) begin
              bit_cnt_nxt = '0;
              if (state == ST_ID) begin
                tx_nxt     = id_byte(id_idx);
                id_idx_nxt = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
              end else begin
                tx_nxt = 8'h00;
              end
            end
          end
        end
        ST_IGNORE: begin
          oe_nxt = 1'b0;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_SPI_MISO    = miso;
  assign o_SPI_MISO_OE = miso_oe;
  assign o_MEM_ADDR    = mem_addr;
  assign o_MEM_RD      = mem_rd;
  assign o_BUSY        = busy;
  assign o_CMD         = cmd;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI initiator model, byte memory model and
// a behavioural expectation model for READ/RDID/RDSR/unknown transfers.
module tb_spi_flash_responder;

  localparam logic [23:0] JEDEC = 24'hEF4016;

  logic        clk;
  logic        reset_n;
  logic        sck, cs, mosi;
  logic        miso, miso_oe;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        busy;
  logic [7:0]  cmd;

  int n_cmp;
  int n_err;
  int half_ns;
  int rd_wide;
  logic rd_prev;
  logic [15:0] strobes[$];

  logic [7:0] tx_buf [0:15];
  logic [7:0] rx_buf [0:15];
  logic       oe_any [0:15];
  logic       oe_all [0:15];
  logic       busy_all;

  spi_flash_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_SPI_CLK     (sck),
    .i_SPI_CS      (cs),
    .i_SPI_MOSI    (mosi),
    .o_SPI_MISO    (miso),
    .o_SPI_MISO_OE (miso_oe),
    .o_MEM_ADDR    (mem_addr),
    .o_MEM_RD      (mem_rd),
    .i_MEM_DATA    (mem_data),
    .o_BUSY        (busy),
    .o_CMD         (cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: byte at address a is a[7:0]^A5, one clk latency.
  always @(posedge clk) begin
    if (mem_rd === 1'b1) mem_data <= mem_addr[7:0] ^ 8'hA5;
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      strobes.push_back(mem_addr);
      if (rd_prev === 1'b1) rd_wide++;
    end
    rd_prev = mem_rd;
  end

  function automatic logic [7:0] exp_read(input logic [23:0] a, input int k);
    logic [15:0] ad;
    ad = 16'(a[15:0] + 16'(k));
    return ad[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] exp_id(input int k);
    logic [23:0] sh;
    sh = JEDEC >> (8 * (2 - (k % 3)));
    return sh[7:0];
  endfunction

  // Mode-0 initiator: clocks nbits from tx_buf, captures MISO before each rise.
  task automatic spi_xfer(input int nbits, input bit keep_cs);
    @(posedge clk);
    #($urandom_range(1, 9));
    busy_all = 1'b1;
    strobes.delete();
    cs = 1'b0;
    sck = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_buf[i / 8][7 - (i % 8)];
      #(half_ns);
      if (i % 8 == 0) begin
        rx_buf[i / 8] = 8'h00;
        oe_any[i / 8] = 1'b0;
        oe_all[i / 8] = 1'b1;
      end
      rx_buf[i / 8] = {rx_buf[i / 8][6:0], miso};
      oe_any[i / 8] = oe_any[i / 8] | miso_oe;
      oe_all[i / 8] = oe_all[i / 8] & miso_oe;
      if (i > 2) busy_all = busy_all & busy;
      sck = 1'b1;
      #(half_ns);
      sck = 1'b0;
    end
    if (!keep_cs) begin
      #(half_ns);
      cs = 1'b1;
      mosi = 1'b0;
      #(200);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (miso !== 1'b0)     begin n_err++; $display("FAIL reset_miso: got %b expected 0", miso); end
    if (miso_oe !== 1'b0)  begin n_err++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
    if (mem_rd !== 1'b0)   begin n_err++; $display("FAIL reset_rd: got %b expected 0", mem_rd); end
    if (mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (cmd !== 8'h00)     begin n_err++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read(input logic [23:0] a, input int nbytes);
    tx_buf[0] = 8'h03;
    tx_buf[1] = a[23:16];
    tx_buf[2] = a[15:8];
    tx_buf[3] = a[7:0];
    for (int k = 4; k < 16; k++) tx_buf[k] = 8'($urandom);
    spi_xfer(32 + 8 * nbytes, 1'b0);
    for (int k = 0; k < nbytes; k++) begin
      n_cmp++;
      if (rx_buf[4 + k] !== exp_read(a, k)) begin
        n_err++;
        $display("FAIL read_data a=%h k=%0d: got %h expected %h", a, k, rx_buf[4 + k], exp_read(a, k));
      end
      n_cmp++;
      if (oe_all[4 + k] !== 1'b1) begin
        n_err++; $display("FAIL read_oe_data k=%0d: got %b expected 1", k, oe_all[4 + k]);
      end
    end
    n_cmp++;
    if ((oe_any[0] | oe_any[1] | oe_any[2] | oe_any[3]) !== 1'b0) begin
      n_err++; $display("FAIL read_oe_hdr: got 1 expected 0");
    end
    n_cmp++;
    if (strobes.size() != nbytes + 1) begin
      n_err++; $display("FAIL read_strobe_count: got %0d expected %0d", strobes.size(), nbytes + 1);
    end
    for (int k = 0; k < strobes.size() && k <= nbytes; k++) begin
      n_cmp++;
      if (strobes[k] !== 16'(a[15:0] + 16'(k))) begin
        n_err++;
        $display("FAIL read_strobe_addr k=%0d: got %h expected %h", k, strobes[k], 16'(a[15:0] + 16'(k)));
      end
    end
    n_cmp += 3;
    if (cmd !== 8'h03)    begin n_err++; $display("FAIL read_cmd: got %h expected 03", cmd); end
    if (busy_all !== 1'b1) begin n_err++; $display("FAIL read_busy_mid: got %b expected 1", busy_all); end
    if (busy !== 1'b0)    begin n_err++; $display("FAIL read_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_rdid(input int nbytes);
    tx_buf[0] = 8'h9F;
    for (int k = 1; k < 16; k++) tx_buf[k] = 8'($urandom);
    spi_xfer(8 + 8 * nbytes, 1'b0);
    for (int k = 0; k < nbytes; k++) begin
      n_cmp += 2;
      if (rx_buf[1 + k] !== exp_id(k)) begin
        n_err++; $display("FAIL rdid_data k=%0d: got %h expected %h", k, rx_buf[1 + k], exp_id(k));
      end
      if (oe_all[1 + k] !== 1'b1) begin
        n_err++; $display("FAIL rdid_oe k=%0d: got %b expected 1", k, oe_all[1 + k]);
      end
    end
    n_cmp += 3;
    if (oe_any[0] !== 1'b0)  begin n_err++; $display("FAIL rdid_oe_op: got %b expected 0", oe_any[0]); end
    if (strobes.size() != 0) begin n_err++; $display("FAIL rdid_strobes: got %0d expected 0", strobes.size()); end
    if (cmd !== 8'h9F)       begin n_err++; $display("FAIL rdid_cmd: got %h expected 9f", cmd); end
  endtask

  task automatic test_rdsr(input int nbytes);
    tx_buf[0] = 8'h05;
    for (int k = 1; k < 16; k++) tx_buf[k] = 8'($urandom);
    spi_xfer(8 + 8 * nbytes, 1'b0);
    for (int k = 0; k < nbytes; k++) begin
      n_cmp += 2;
      if (rx_buf[1 + k] !== 8'h00) begin
        n_err++; $display("FAIL rdsr_data k=%0d: got %h expected 00", k, rx_buf[1 + k]);
      end
      if (oe_all[1 + k] !== 1'b1) begin
        n_err++; $display("FAIL rdsr_oe k=%0d: got %b expected 1", k, oe_all[1 + k]);
      end
    end
    n_cmp += 2;
    if (strobes.size() != 0) begin n_err++; $display("FAIL rdsr_strobes: got %0d expected 0", strobes.size()); end
    if (cmd !== 8'h05)       begin n_err++; $display("FAIL rdsr_cmd: got %h expected 05", cmd); end
  endtask

  task automatic test_unknown(input logic [7:0] op, input int nbytes);
    logic seen;
    tx_buf[0] = op;
    for (int k = 1; k < 16; k++) tx_buf[k] = 8'($urandom);
    spi_xfer(8 + 8 * nbytes, 1'b0);
    seen = 1'b0;
    for (int k = 0; k <= nbytes; k++) seen = seen | oe_any[k];
    n_cmp += 3;
    if (seen !== 1'b0)       begin n_err++; $display("FAIL unk_oe op=%h: got 1 expected 0", op); end
    if (strobes.size() != 0) begin n_err++; $display("FAIL unk_strobes: got %0d expected 0", strobes.size()); end
    if (cmd !== op)          begin n_err++; $display("FAIL unk_cmd: got %h expected %h", cmd, op); end
  endtask

  task automatic test_abort();
    tx_buf[0] = 8'h03;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'h77;
    tx_buf[3] = 8'h88;
    spi_xfer(8 + 12, 1'b0);
    n_cmp += 2;
    if (strobes.size() != 0) begin n_err++; $display("FAIL abort_strobes: got %0d expected 0", strobes.size()); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    test_read(24'h000010, 1);
  endtask

  task automatic test_reset_mid_data();
    tx_buf[0] = 8'h03;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'h12;
    tx_buf[3] = 8'h34;
    spi_xfer(32 + 12, 1'b1);
    n_cmp++;
    if (miso_oe !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_oe: got %b expected 1", miso_oe); end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp += 6;
    if (miso !== 1'b0)      begin n_err++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
    if (miso_oe !== 1'b0)   begin n_err++; $display("FAIL rstmid_oe: got %b expected 0", miso_oe); end
    if (mem_rd !== 1'b0)    begin n_err++; $display("FAIL rstmid_rd: got %b expected 0", mem_rd); end
    if (mem_addr !== 16'h0) begin n_err++; $display("FAIL rstmid_addr: got %h expected 0000", mem_addr); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (cmd !== 8'h00)      begin n_err++; $display("FAIL rstmid_cmd: got %h expected 00", cmd); end
    reset_n = 1'b1;
    cs = 1'b1;
    mosi = 1'b0;
    #(200);
    test_read(24'($urandom), 2);
  endtask

  task automatic test_random(input int iters);
    logic [7:0] op;
    for (int it = 0; it < iters; it++) begin
      case ($urandom_range(0, 3))
        0: test_read(24'($urandom), int'($urandom_range(1, 4)));
        1: test_rdid(int'($urandom_range(1, 5)));
        2: test_rdsr(int'($urandom_range(1, 3)));
        default: begin
          op = 8'($urandom);
          if (op == 8'h03 || op == 8'h9F || op == 8'h05) op = 8'hAB;
          test_unknown(op, 2);
        end
      endcase
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rd_wide = 0;
    rd_prev = 1'b0;
    mem_data = 8'h00;
    cs = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    reset_n = 1'b0;
    half_ns = 40;
    test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      half_ns = (pass == 0) ? 40 : 80;
      test_read(24'h001234, 3);
      test_read(24'h00FFFF, 2);
      test_rdid(4);
      test_rdsr(2);
      test_unknown(8'hAB, 2);
      test_abort();
      test_reset_mid_data();
      test_random(6);
    end
    n_cmp++;
    if (rd_wide != 0) begin n_err++; $display("FAIL strobe_width: got %0d wide strobes expected 0", rd_wide); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
